// File: rtl/regfile_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sweep
//  Brief    : MIPS32 general-purpose register file. Two combinational read
//             ports with same-cycle write-through bypass, one write-back
//             port, r0 hardwired to zero. After reset a clear-sweep FSM
//             zeroes one register per cycle while busy stalls the pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sweep #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_zero = '0;
  localparam int                c_nrd  = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;

  // Storage is deliberately not reset; the sweep is the only clear mechanism.
  logic [DATA_W-1:0]   r_mem [NREG];

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_in_clear;

  logic                w_re    [c_nrd];
  logic [ADDR_W-1:0]   w_raddr [c_nrd];
  logic [DATA_W-1:0]   w_rdata [c_nrd];

  assign w_in_clear = (r_state == ST_CLEAR);

  // Stall request is a pure decode of the registered state.
  assign busy = w_in_clear;

  // State and sweep counter register; reset always restarts a full sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= c_zero;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: step the counter through every register, then go READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_cnt == c_last) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = c_zero;
        end else begin
          w_cnt_nxt   = r_cnt + c_one;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
        w_cnt_nxt   = c_zero;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = c_zero;
      end
    endcase
  end

  // Array write mux: sweep owns the port in CLEAR, WB owns it in READY.
  // WB writes during the sweep and writes to r0 are dropped.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_cnt;
    w_mem_data = '0;
    if (!rst) begin
      if (w_in_clear) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = '0;
      end else if (we && (waddr != c_zero)) begin
        w_mem_we   = 1'b1;
        w_mem_addr = waddr;
        w_mem_data = wdata;
      end
    end
  end

  // Single write port into the storage array.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign w_re[0]    = re1;
  assign w_raddr[0] = raddr1;
  assign w_re[1]    = re2;
  assign w_raddr[1] = raddr2;

  // Identical, independent read ports with write-through bypass.
  for (genvar gi = 0; gi < c_nrd; gi++) begin : g_read_port
    // Priority: invalid file, disabled port, r0, bypass, array.
    always_comb begin
      w_rdata[gi] = '0;
      if (rst || w_in_clear) begin
        w_rdata[gi] = '0;
      end else if (!w_re[gi]) begin
        w_rdata[gi] = '0;
      end else if (w_raddr[gi] == c_zero) begin
        w_rdata[gi] = '0;
      end else if (we && (waddr == w_raddr[gi])) begin
        w_rdata[gi] = wdata;
      end else begin
        w_rdata[gi] = r_mem[w_raddr[gi]];
      end
    end
  end

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sweep
//  Brief    : Directed self-checking bench for regfile_sweep. Expected
//             values are queued when stimulus is driven and compared at the
//             falling edge, when the combinational outputs are stable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sweep;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: port 0 = busy, 1 = rdata1, 2 = rdata2
  string             tag_q  [$];
  int                port_q [$];
  logic [DATA_W-1:0] exp_q  [$];

  regfile_sweep #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREG  (NREG)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [DATA_W-1:0] exp);
    tag_q.push_back(tag);
    port_q.push_back(port);
    exp_q.push_back(exp);
  endtask

  // Compare every queued expectation against the DUT outputs now.
  task automatic drain();
    string             t;
    int                p;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] o;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      p = port_q.pop_front();
      e = exp_q.pop_front();
      case (p)
        0:       o = {{(DATA_W-1){1'b0}}, busy};
        1:       o = rdata1;
        default: o = rdata2;
      endcase
      chk(t, o, e);
    end
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic sample();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after rst is released. Counts cycles with busy high, checks
  // reads are zeroed meanwhile, and optionally drops we as soon as busy falls.
  task automatic measure_sweep(input string tag, input logic drop_we);
    int n    = 0;
    bit done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (busy) begin
        n++;
        push({tag, "_rd_in_clear"}, 1, '0);
        drain();
        @(posedge clk);
        #1;
      end else begin
        done = 1;
        if (drop_we) we = 1'b0;
      end
    end
    chk({tag, "_busy_cycles"}, DATA_W'(n), DATA_W'(NREG));
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    re1 = 1'b1;
    re2 = 1'b1;
    we  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      raddr1 = ADDR_W'(i);
      raddr2 = ADDR_W'(NREG - 1 - i);
      push({tag, "_p1"}, 1, '0);
      push({tag, "_p2"}, 2, '0);
      sample();
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;

    // Reset state
    step();
    push("rst_busy", 0, 32'd1);
    push("rst_rd1",  1, '0);
    push("rst_rd2",  2, '0);
    sample();

    // Sweep length after a clean reset release
    raddr1 = 5'd3;
    rst = 1'b0;
    measure_sweep("sweep1", 1'b0);
    push("ready_busy", 0, '0);
    sample();
    read_all_zero("clear1");

    // Write then read r5
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; re1 = 1'b0; re2 = 1'b0;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    push("r5_read", 1, 32'h1234_5678);
    sample();
    re1 = 1'b0;
    push("r5_re_off", 1, '0);
    sample();

    // Write-through on both ports, then array hold
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
    push("wt_rd1", 1, 32'hDEAD_BEEF);
    push("wt_rd2", 2, 32'hDEAD_BEEF);
    sample();
    we = 1'b0; wdata = '0;
    push("r7_hold_rd1", 1, 32'hDEAD_BEEF);
    push("r7_hold_rd2", 2, 32'hDEAD_BEEF);
    sample();

    // r0 immunity, same and following cycle; r5 still intact
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd5;
    push("r0_same", 1, '0);
    push("r5_keep", 2, 32'h1234_5678);
    sample();
    we = 1'b0;
    push("r0_next", 1, '0);
    sample();

    // Bypass must not leak to the other port reading a different address
    we = 1'b1; waddr = 5'd12; wdata = 32'h0BAD_F00D; raddr1 = 5'd12; raddr2 = 5'd7;
    push("wt_r12", 1, 32'h0BAD_F00D);
    push("r7_other", 2, 32'hDEAD_BEEF);
    sample();
    we = 1'b0;

    // Writes to r3 held through an entire sweep must be discarded
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; raddr1 = 5'd3;
    step();
    rst = 1'b0;
    measure_sweep("sweep_we", 1'b1);
    raddr1 = 5'd3; raddr2 = 5'd12;
    push("r3_dropped", 1, '0);
    push("r12_cleared", 2, '0);
    sample();

    // Mid-sweep reset restarts the full sweep
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
    step();
    we = 1'b0; raddr1 = 5'd9;
    push("r9_load", 1, 32'h0000_0055);
    sample();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    push("mid_busy", 0, 32'd1);
    sample();
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure_sweep("sweep_mid", 1'b0);
    read_all_zero("clear2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop guard against a stalled sequence.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
